// File: rtl/fft_mem_sequencer_if.sv
// Control/address bundle between the FFT memory sequencer and the ping-pong
// data memory / butterfly datapath.
interface fft_mem_sequencer_if #(
  parameter int LOG2N = 4
);
  logic             start;
  logic             busy;
  logic             done;
  logic             select;
  logic             write_enable;
  logic [LOG2N-1:0] addr_1;
  logic [LOG2N-1:0] addr_2;
  logic [LOG2N-1:0] addw_1;
  logic [LOG2N-1:0] addw_2;
  logic             bf_in_valid;
  logic [LOG2N-2:0] tw_idx;
  logic [LOG2N-1:0] stage;

  modport master (
    input  start,
    output busy, done, select, write_enable,
    output addr_1, addr_2, addw_1, addw_2,
    output bf_in_valid, tw_idx, stage
  );

  modport slave (
    output start,
    input  busy, done, select, write_enable,
    input  addr_1, addr_2, addw_1, addw_2,
    input  bf_in_valid, tw_idx, stage
  );
endinterface

// File: rtl/fft_mem_sequencer.sv
// Address/control sequencer for an in-place radix-2 DIF FFT over a two-bank
// ping-pong memory: one butterfly read per cycle, write-back PIPE cycles later.
module fft_mem_sequencer #(
  parameter int LOG2N  = 4,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  fft_mem_sequencer_if.master bus
);
  localparam int N    = 1 << LOG2N;
  localparam int B    = N / 2;
  localparam int PIPE = RD_LAT + BF_LAT;
  localparam int KW   = LOG2N - 1;
  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);
  localparam logic [KW-1:0]    LAST_K     = KW'(B - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic [LOG2N-1:0] stage_q;
  logic             sel_q;

  logic             pv_q    [PIPE];
  logic             plast_q [PIPE];
  logic [LOG2N-1:0] pa1_q   [PIPE];
  logic [LOG2N-1:0] pa2_q   [PIPE];
  logic [KW-1:0]    ptw_q   [RD_LAT];

  logic             issue_d, last_d;
  logic [LOG2N-1:0] kx, half, j, g, a1_d, a2_d;
  logic [KW-1:0]    tw_d;
  logic             tail_last;

  // Butterfly k of stage s pairs a1 and a1+half inside group g.
  always_comb begin
    issue_d = (state_q == ISSUE);
    last_d  = (k_q == LAST_K);
    kx      = LOG2N'(k_q);
    half    = LOG2N'(N >> (int'(stage_q) + 1));
    j       = kx & (half - LOG2N'(1));
    g       = kx >> (LOG2N - 1 - int'(stage_q));
    a1_d    = (g << (LOG2N - int'(stage_q))) | j;
    a2_d    = a1_d + half;
    tw_d    = KW'(j << stage_q);
  end

  assign tail_last = pv_q[PIPE-1] & plast_q[PIPE-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      stage_q <= '0;
      sel_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sel_q   <= ~sel_q;
            stage_q <= '0;
            k_q     <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (k_q == LAST_K) state_q <= DRAIN;
          else               k_q     <= k_q + KW'(1);
        end
        DRAIN: begin
          // Next stage may only begin once its last write-back has landed.
          if (tail_last) begin
            sel_q <= ~sel_q;
            if (stage_q == LAST_STAGE) begin
              state_q <= IDLE;
            end else begin
              stage_q <= stage_q + LOG2N'(1);
              k_q     <= '0;
              state_q <= ISSUE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data fields advance only with a valid entry so the tail holds the last write address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++) begin
        pv_q[i]    <= 1'b0;
        plast_q[i] <= 1'b0;
        pa1_q[i]   <= '0;
        pa2_q[i]   <= '0;
      end
      for (int i = 0; i < RD_LAT; i++) ptw_q[i] <= '0;
    end else begin
      pv_q[0] <= issue_d;
      if (issue_d) begin
        plast_q[0] <= last_d;
        pa1_q[0]   <= a1_d;
        pa2_q[0]   <= a2_d;
        ptw_q[0]   <= tw_d;
      end
      for (int i = 1; i < PIPE; i++) begin
        pv_q[i] <= pv_q[i-1];
        if (pv_q[i-1]) begin
          plast_q[i] <= plast_q[i-1];
          pa1_q[i]   <= pa1_q[i-1];
          pa2_q[i]   <= pa2_q[i-1];
        end
      end
      for (int i = 1; i < RD_LAT; i++) begin
        if (pv_q[i-1]) ptw_q[i] <= ptw_q[i-1];
      end
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = tail_last & (state_q == DRAIN) & (stage_q == LAST_STAGE);
  assign bus.select       = sel_q;
  assign bus.stage        = stage_q;
  assign bus.addr_1       = issue_d ? a1_d : '0;
  assign bus.addr_2       = issue_d ? a2_d : '0;
  assign bus.write_enable = pv_q[PIPE-1];
  assign bus.addw_1       = pa1_q[PIPE-1];
  assign bus.addw_2       = pa2_q[PIPE-1];
  assign bus.bf_in_valid  = pv_q[RD_LAT-1];
  assign bus.tw_idx       = ptw_q[RD_LAT-1];
endmodule

// File: tb/tb_fft_mem_sequencer.sv
// Bench for fft_mem_sequencer: directed runs with random start noise, compared
// cycle by cycle against a schedule computed from the FFT addressing rules.
module tb_fft_mem_sequencer;
  localparam int LOG2N  = 4;
  localparam int N      = 1 << LOG2N;
  localparam int B      = N / 2;
  localparam int RD_LAT = 1;
  localparam int BF_LAT = 3;
  localparam int PIPE   = RD_LAT + BF_LAT;
  localparam int STG    = B + PIPE;
  localparam int RUN    = LOG2N * STG;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic sel_exp = 1'b0;

  always #5 clk = ~clk;

  fft_mem_sequencer_if #(.LOG2N(LOG2N)) bus ();

  fft_mem_sequencer #(.LOG2N(LOG2N), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference addressing: stage s, butterfly k.
  function automatic void bfly(input int s, input int k, output int a1, output int a2, output int tw);
    int half, jj, gg;
    half = N >> (s + 1);
    jj   = k % half;
    gg   = k / half;
    a1   = 2 * gg * half + jj;
    a2   = a1 + half;
    tw   = jj << s;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " done"}, bus.done, 0);
    chk({tag, " select"}, bus.select, 0);
    chk({tag, " we"}, bus.write_enable, 0);
    chk({tag, " bfv"}, bus.bf_in_valid, 0);
    chk({tag, " addr_1"}, bus.addr_1, 0);
    chk({tag, " addr_2"}, bus.addr_2, 0);
    chk({tag, " addw_1"}, bus.addw_1, 0);
    chk({tag, " addw_2"}, bus.addw_2, 0);
    chk({tag, " tw"}, bus.tw_idx, 0);
    chk({tag, " stage"}, bus.stage, 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " done"}, bus.done, 0);
    chk({tag, " select"}, bus.select, sel_exp);
    chk({tag, " we"}, bus.write_enable, 0);
    chk({tag, " bfv"}, bus.bf_in_valid, 0);
    chk({tag, " addr_1"}, bus.addr_1, 0);
    chk({tag, " addr_2"}, bus.addr_2, 0);
  endtask

  // One full FFT from IDLE; random start pulses in [inj_lo,inj_hi] must be ignored.
  task automatic run_fft(input int inj_lo, input int inj_hi, input bit start_at_done, input int abort_at);
    logic sel_base;
    int   s, pos, a1, a2, tw, wcnt;
    string t;
    sel_base = sel_exp;
    wcnt = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= RUN; c++) begin
      s   = (c - 1) / STG;
      pos = (c - 1) % STG;
      t   = $sformatf("c%0d", c);
      chk({t, " busy"}, bus.busy, 1);
      chk({t, " stage"}, bus.stage, s);
      chk({t, " select"}, bus.select, sel_base ^ 1'b1 ^ 1'(s & 1));
      if (pos < B) begin
        bfly(s, pos, a1, a2, tw);
        chk({t, " addr_1"}, bus.addr_1, a1);
        chk({t, " addr_2"}, bus.addr_2, a2);
      end
      chk({t, " bfv"}, bus.bf_in_valid, (pos >= RD_LAT && pos < B + RD_LAT));
      if (pos >= RD_LAT && pos < B + RD_LAT) begin
        bfly(s, pos - RD_LAT, a1, a2, tw);
        chk({t, " tw"}, bus.tw_idx, tw);
      end
      chk({t, " we"}, bus.write_enable, (pos >= PIPE));
      if (pos >= PIPE) begin
        bfly(s, pos - PIPE, a1, a2, tw);
        chk({t, " addw_1"}, bus.addw_1, a1);
        chk({t, " addw_2"}, bus.addw_2, a2);
      end
      if (s == LOG2N - 1 && bus.write_enable === 1'b1) wcnt++;
      chk({t, " done"}, bus.done, (c == RUN));
      if (c == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset("abort");
        sel_exp = 1'b0;
        return;
      end
      bus.start = (c >= inj_lo && c <= inj_hi) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (start_at_done && c == RUN) bus.start = 1'b1;
      step();
      bus.start = 1'b0;
    end
    chk("last stage write count", wcnt, B);
    sel_exp = ~sel_base;
    chk_idle("post-run");
    step();
    chk_idle("post-run+1");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chk_reset("reset");
    for (int i = 0; i < 5; i++) begin
      step();
      chk_idle($sformatf("idle%0d", i));
    end

    // Clean run: stage 0 select=1, final select=1.
    repeat ($urandom_range(0, 3)) step();
    run_fft(1, 0, 1'b0, 0);

    // Second run starts with select=0; start noise in stage 2 and start coincident with done.
    run_fft(2 * STG + 1, 3 * STG, 1'b1, 0);

    // Reset during stage 1 drain, then confirm quiet idle.
    repeat ($urandom_range(0, 3)) step();
    run_fft(1, 0, 1'b0, STG + B + 2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle($sformatf("after-abort%0d", i));
    end

    // Clean run after reset, then random start noise across a whole run.
    run_fft(1, 0, 1'b0, 0);
    repeat ($urandom_range(0, 3)) step();
    run_fft(1, RUN, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_mem_sequencer.md
Name: fft_mem_sequencer

Overview:
- Address and control sequencer for the ping-pong two-bank FFT data memory.
- Drives the read and write address pairs, write_enable and bank select for an in-place radix-2 decimation-in-frequency FFT of N = 2^LOG2N points.
- Issues one butterfly read pair per cycle and tells the butterfly datapath when operand data is valid and which twiddle to use.
- Writes results back after a fixed pipeline delay, then toggles banks every stage.

Parameters:
LOG2N, 4, log2 of the FFT size; also the address width (N = 16 by default).
RD_LAT, 1, read latency of the memory in cycles (address to dout).
BF_LAT, 3, butterfly datapath latency in cycles (operands in to results out).

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to run a full FFT on the memory contents
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the last write of the last stage completes
select  output  1  bank select to the memory: 1 = read bank A / write bank B; 0 = the reverse
write_enable  output  1  write strobe to the memory
addr_1  output  LOG2N  read address, upper butterfly leg
addr_2  output  LOG2N  read address, lower butterfly leg
addw_1  output  LOG2N  write address, upper leg
addw_2  output  LOG2N  write address, lower leg
bf_in_valid  output  1  memory dout holds a valid operand pair this cycle
tw_idx  output  LOG2N-1  twiddle index for the operands flagged by bf_in_valid
stage  output  LOG2N bits (sized to hold 0..LOG2N-1)  current stage number

Behaviour:
Reset values and derived constants:
- Reset values: busy=0, done=0, select=0, write_enable=0, bf_in_valid=0, all addresses 0, tw_idx=0, stage=0, FSM=IDLE, pipeline empty.
- Derived: PIPE = RD_LAT + BF_LAT; B = N/2 butterflies per stage.

FSM states IDLE, ISSUE, DRAIN:
- IDLE: start=1 -> select toggles, stage=0, k=0, go to ISSUE, busy=1 next cycle. In IDLE all addresses read 0 and write_enable=0.
- ISSUE: k = 0..B-1, one butterfly per cycle. After k=B-1 is issued, go to DRAIN.
- DRAIN: wait until the write of butterfly B-1 occurs, i.e. PIPE cycles after its issue.
  - On that write cycle, if stage < LOG2N-1: next cycle stage+1, select toggles, k=0, ISSUE.
  - Otherwise: done=1 for that one cycle only; next cycle select toggles, busy=0, IDLE.
- Reads of a new stage never overlap writes of the previous stage (no RAW hazard).
- Stage length is B+PIPE cycles. Total run is LOG2N*(B+PIPE) cycles; 48 cycles at the defaults.

Select toggling:
- select toggles at start, at each stage boundary, and at completion: LOG2N+1 toggles per FFT.
- When idle after a run, select reads the bank holding the result.

Address generation, stage s, butterfly k:
- half = N >> (s+1); j = k mod half; g = k / half.
- addr_1 = 2*g*half + j; addr_2 = addr_1 + half.
- Twiddle index = j << s (LOG2N-1 bits).
- Read addresses are driven combinationally from the registered counters during ISSUE.

Write path:
- A PIPE-deep shift register carries (valid, addr_1, addr_2).
- Output stage drives write_enable, addw_1, addw_2, so a write occurs exactly PIPE cycles after issue.
- A second tap at depth RD_LAT carries (valid, tw_idx) and drives bf_in_valid and tw_idx.
- write_enable is 0 whenever the tail entry is invalid; addw_1/addw_2 then hold their last values.

Boundary conditions:
- start while busy: ignored.
- start in the same cycle as done: ignored; the next start is accepted in IDLE.
- rst mid-run: everything returns to reset values next cycle, including the pipeline and select; no further writes occur.
- Counter k wraps only via the FSM transition, never arithmetically.

Test Plan:
1. Reset then idle 5 cycles -> select=0, write_enable=0, busy=0, done=0 throughout.
2. Single start at defaults:
   - Stage 0 reads (0,8),(1,9)...(7,15).
   - tw_idx on bf_in_valid cycles is 0..7.
   - First write_enable is 4 cycles after the first read, with addw=(0,8).
   - select=1 during stage 0.
3. Stage address and twiddle checks:
   - Stage 1: k=5 gives (9,13), tw=2.
   - Stage 3: k=5 gives (10,11), tw=0.
   - Stage 3: write_enable count = 8, with no write in a cycle that reads the same stage's first butterfly.
4. Full run timing:
   - done pulses at cycle 48 after start acceptance.
   - select sequence over the run: 1,0,1,0, then 1 when idle.
   - busy falls the cycle after done.
   - A second run starts with select=0.
5. Inject start during stage 2 -> no effect; done still at cycle 48.
6. Assert rst during stage 1 DRAIN -> next cycle write_enable=0, select=0, stage=0, busy=0; a subsequent start runs a clean 48-cycle FFT.
